sram_resp: RTL and testbench
============================

SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 SHALL provide parameter LAT, default 2: cycles from request acceptance to data_ok, legal range 1..7.
REQ-002 SHALL provide parameter QDEPTH, default 2: maximum outstanding requests, legal range 2..4.
REQ-003 SHALL provide parameter AW, default 10: word-index width; memory holds 2^AW 32-bit words.
REQ-004 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 1: request valid from the initiator.
REQ-007 SHALL have port wr, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port wstrb, input, 4: byte-lane write enables, used only when wr=1.
REQ-009 SHALL have port addr, input, 32: byte address; bits [AW+1:2] select the word, all other bits are ignored.
REQ-010 SHALL have port wdata, input, 32: write data.
REQ-011 SHALL have port addr_ok, output, 1: request accepted this cycle when req=1.
REQ-012 SHALL have port data_ok, output, 1: response valid this cycle (one-cycle pulse per request).
REQ-013 SHALL have port rdata, output, 32: read data, qualified by data_ok.

Function
REQ-014 SHALL accept a request on a rising edge where req=1 and addr_ok=1.
REQ-015 SHALL drive addr_ok = (outstanding count < QDEPTH); there is no bypass from a same-cycle pop.
REQ-016 SHALL perform a write at the accept edge, updating only the byte lanes whose wstrb bit is set.
REQ-017 SHALL, for a read, capture the memory word at the accept edge into the queue entry, so an earlier write to the same word is observed (in-order RAW).
REQ-018 SHALL, for a write, still enqueue an entry; its response is a data_ok pulse with rdata=0.
REQ-019 SHALL load each entry's countdown with LAT-1 at accept and decrement it by 1 per cycle, saturating at 0.
REQ-020 SHALL drive data_ok=1 combinationally when the head entry is valid and its countdown=0; the head is popped at that edge.
REQ-021 SHALL return responses strictly in acceptance order; there is no back-pressure on data_ok.
REQ-022 SHALL drive rdata = head data while data_ok=1, and 0 otherwise.
REQ-023 SHALL give accepts spaced by at least 1 cycle a response latency of exactly LAT cycles: accept at edge N gives data_ok high in the cycle after edge N+LAT-1.
REQ-024 SHALL, on simultaneous accept and pop, leave the count unchanged and wrap the queue pointers modulo QDEPTH.
REQ-025 SHALL, when the queue is full, hold addr_ok=0; it rises the cycle after a pop.
REQ-026 SHALL wrap addr bits above AW+1 onto the same word (aliasing).

Reset
REQ-027 SHALL, while reset=1, asynchronously clear the queue: count=0, pointers=0, all entries invalid, data_ok=0, rdata=0, addr_ok=0.
REQ-028 SHALL drop any requests in flight at reset assertion, with no data_ok issued for them; writes that were already accepted remain in memory.
REQ-029 SHALL NOT clear the memory array on reset.
REQ-030 SHALL drive addr_ok=1 in the first cycle after reset deasserts.

Structure
REQ-031 SHALL place the word width (32), strobe width (4) and the LAT/QDEPTH legal limits in shared package sram_if_pkg, reused by CPU-side initiators.
REQ-032 SHALL implement the in-order queue (entries, countdowns, pointers, count) as sub-module resp_queue; the memory array and write-strobe logic stay in sram_resp.

Verification
REQ-033 SHALL verify a single read: preload word 0x10 with 0x12345678, read addr 0x40 with LAT=2 -> data_ok exactly 2 cycles later with rdata=0x12345678.
REQ-034 SHALL verify byte writes: write 0xAABBCCDD with wstrb=0101 to a word holding 0x00000000, then read it -> 0x00BB00DD.
REQ-035 SHALL verify RAW back-to-back: write 0xCAFEF00D, then read the same address on the next cycle -> read data_ok returns 0xCAFEF00D, one cycle after the write's data_ok.
REQ-036 SHALL verify a full queue: QDEPTH=2, LAT=4, req held high -> addr_ok falls after 2 accepts and rises the cycle after the first data_ok; responses arrive in order.
REQ-037 SHALL verify aliasing: write to 0x00001004, read 0x00000004 -> same data.
REQ-038 SHALL verify reset mid-flight: reset with 2 reads outstanding -> no data_ok; addr_ok=1 the first cycle after release; prior memory contents intact.

Source files
------------

// File: rtl/sram_if_pkg.sv
// Shared SRAM-interface definitions: bus widths, legal parameter limits
// and the response-queue entry layout used by sram_resp and CPU-side initiators.
package sram_if_pkg;

  localparam int WORD_W     = 32;
  localparam int STRB_W     = 4;
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 7;
  localparam int QDEPTH_MIN = 2;
  localparam int QDEPTH_MAX = 4;

  // A countdown never holds more than LAT_MAX-1, so this width covers every legal LAT.
  localparam int CNT_W = $clog2(LAT_MAX);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [STRB_W-1:0] strb_t;

  // One outstanding request: its cycles-to-go and the data it will return.
  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] cnt;
    word_t            data;
  } entry_t;

endpackage

// File: rtl/resp_queue.sv
// In-order response queue. Each accepted request gets an entry whose
// countdown starts at LAT-1; the head entry is returned (and popped) on the
// cycle its countdown reaches zero. There is no back-pressure on the response.
module resp_queue
  import sram_if_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int QDEPTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push_i,
  input  word_t pushData_i,
  output logic  notFull_o,
  output logic  respValid_o,
  output word_t respData_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  entry_t          entries_q [QDEPTH];
  entry_t          entries_d [QDEPTH];
  logic [PW-1:0]   headPtr_q, headPtr_d;
  logic [PW-1:0]   tailPtr_q, tailPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop;

  // Pointers wrap modulo QDEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop         = entries_q[headPtr_q].valid && (entries_q[headPtr_q].cnt == '0);
  assign respValid_o = pop;
  assign respData_o  = pop ? entries_q[headPtr_q].data : '0;
  assign notFull_o   = (count_q < CW'(QDEPTH));

  // Next-state: age every entry, retire the head when due, append a new request.
  always_comb begin
    entries_d = entries_q;
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q + CW'(push_i) - CW'(pop);
    for (int i = 0; i < QDEPTH; i++) begin
      if (entries_q[i].valid && (entries_q[i].cnt != '0)) begin
        entries_d[i].cnt = entries_q[i].cnt - CNT_W'(1);
      end
    end
    if (pop) begin
      entries_d[headPtr_q].valid = 1'b0;
      headPtr_d = nextPtr(headPtr_q);
    end
    if (push_i) begin
      entries_d[tailPtr_q].valid = 1'b1;
      entries_d[tailPtr_q].cnt   = CNT_W'(LAT - 1);
      entries_d[tailPtr_q].data  = pushData_i;
      tailPtr_d = nextPtr(tailPtr_q);
    end
  end

  // Queue state register; reset drops every in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entries_q[i] <= '0;
      end
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/sram_resp.sv
// Fixed-latency SRAM responder: a 2^AW x 32 word memory with byte-lane
// writes, fronted by an in-order queue that returns one data_ok pulse per
// accepted request LAT cycles after acceptance. Reads sample the memory at
// the accept edge, so they see every earlier accepted write.
module sram_resp
  import sram_if_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int QDEPTH = 2,
  parameter int AW     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  strb_t       wstrb,
  input  logic [31:0] addr,
  input  word_t       wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output word_t       rdata
);

  word_t          mem_q [2**AW];
  logic [AW-1:0]  wordIdx;
  logic           accept;
  logic           notFull;
  word_t          rdWord;
  word_t          pushData;
  logic           unusedAddr;

  // Byte offset and bits above the word index are ignored, which aliases the upper address space.
  assign wordIdx    = addr[AW+1:2];
  assign unusedAddr = ^{addr[31:AW+2], addr[1:0]};

  assign addr_ok  = !reset && notFull;
  assign accept   = req && addr_ok;
  assign rdWord   = mem_q[wordIdx];
  assign pushData = wr ? '0 : rdWord;

  // Memory write at the accept edge; only strobed byte lanes change and reset never touches contents.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_q[wordIdx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  resp_queue #(
    .LAT    (LAT),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (accept),
    .pushData_i  (pushData),
    .notFull_o   (notFull),
    .respValid_o (data_ok),
    .respData_o  (rdata)
  );

endmodule

// File: tb/tb_sram_resp.sv
// Self-checking bench for sram_resp. Two instances (LAT=2 and LAT=4, both
// QDEPTH=2) share one stimulus stream; each is compared every cycle against
// a queue-of-responses model with its own memory image.
module tb_sram_resp;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;
  localparam int QD    = 2;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addrOkA, addrOkB;
  logic        dataOkA, dataOkB;
  logic [31:0] rdataA, rdataB;

  sram_resp #(.LAT(LAT_A), .QDEPTH(QD), .AW(AW)) dutA (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addrOkA), .data_ok(dataOkA), .rdata(rdataA)
  );

  sram_resp #(.LAT(LAT_B), .QDEPTH(QD), .AW(AW)) dutB (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addrOkB), .data_ok(dataOkB), .rdata(rdataB)
  );

  always #5 clk = ~clk;

  typedef struct { int readyEdge; logic [31:0] data; } resp_t;
  typedef struct { int edgeNo; logic [31:0] data; } seen_t;

  resp_t       expQ [2][$];
  seen_t       seenLog [2][$];
  logic [31:0] modelMem [2][1024];
  logic [31:0] initVal [32];
  logic [1:0]  lastAddrOk;
  logic [1:0]  lastDataOk;
  int          edgeCnt = 0;
  int          checks  = 0;
  int          errors  = 0;

  function automatic int latOf(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic logic obsAddrOk(input int k);
    return (k == 0) ? addrOkA : addrOkB;
  endfunction

  function automatic logic obsDataOk(input int k);
    return (k == 0) ? dataOkA : dataOkB;
  endfunction

  function automatic logic [31:0] obsRdata(input int k);
    return (k == 0) ? rdataA : rdataB;
  endfunction

  // Room for another request whenever fewer than QDEPTH responses are owed.
  function automatic logic expAddrOk(input int k);
    return !reset && (expQ[k].size() < QD);
  endfunction

  // The oldest owed response is due LAT-1 edges after its accept edge.
  function automatic logic expDataOk(input int k);
    if (reset || expQ[k].size() == 0) return 1'b0;
    return expQ[k][0].readyEdge <= edgeCnt;
  endfunction

  function automatic logic [31:0] expRdata(input int k);
    if (!expDataOk(k)) return 32'h0;
    return expQ[k][0].data;
  endfunction

  function automatic logic [31:0] makeAddr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[11:2] = 10'(idx);
    return a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, check both DUTs mid-cycle, then advance the model across the edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] d);
    logic  acc [2];
    logic  pop [2];
    int    idx;
    resp_t e;
    seen_t sv;
    req = r; wr = w; wstrb = s; addr = a; wdata = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("addr_ok%0d", k), 32'(obsAddrOk(k)), 32'(expAddrOk(k)));
      checkOutput($sformatf("data_ok%0d", k), 32'(obsDataOk(k)), 32'(expDataOk(k)));
      checkOutput($sformatf("rdata%0d", k), obsRdata(k), expRdata(k));
      lastAddrOk[k] = obsAddrOk(k);
      lastDataOk[k] = obsDataOk(k);
      if (obsDataOk(k)) begin
        sv.edgeNo = edgeCnt;
        sv.data   = obsRdata(k);
        seenLog[k].push_back(sv);
      end
      acc[k] = r && expAddrOk(k);
      pop[k] = expDataOk(k);
    end
    @(posedge clk);
    edgeCnt++;
    idx = int'(a[11:2]);
    for (int k = 0; k < 2; k++) begin
      if (pop[k]) void'(expQ[k].pop_front());
      if (acc[k]) begin
        e.readyEdge = edgeCnt + latOf(k) - 1;
        if (w) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) modelMem[k][idx][8*b +: 8] = d[8*b +: 8];
          end
          e.data = 32'h0;
        end else begin
          e.data = modelMem[k][idx];
        end
        expQ[k].push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Present a request only once both instances can take it, so their memories stay alike.
  task automatic sendBoth(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!(expAddrOk(0) && expAddrOk(1)) && n < 20) begin
      idle();
      n++;
    end
    checkOutput("send_wait", 32'(n < 20), 32'd1);
    applyStimulus(1'b1, w, s, a, d);
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ[0].size() != 0 || expQ[1].size() != 0) && n < 20) begin
      idle();
      n++;
    end
    idle();
    checkOutput("drain_wait", 32'(n < 20), 32'd1);
  endtask

  task automatic clearLogs();
    seenLog[0].delete();
    seenLog[1].delete();
  endtask

  // Assert reset mid-cycle, check the cleared outputs, hold it two cycles and release.
  task automatic doReset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_addr_ok%0d", k), 32'(obsAddrOk(k)), 32'd0);
      checkOutput($sformatf("rst_data_ok%0d", k), 32'(obsDataOk(k)), 32'd0);
      checkOutput($sformatf("rst_rdata%0d", k), obsRdata(k), 32'h0);
      expQ[k].delete();
    end
    idle();
    idle();
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0]  aPat, dPat;
    logic [31:0] val;
    int          acceptEdge;

    reset = 1'b1; req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    @(negedge clk);
    doReset();
    idle();
    checkOutput("addr_ok_after_first_reset", 32'(lastAddrOk[1]), 32'd1);

    // Fill words 0..31 with known content.
    for (int w = 0; w < 32; w++) begin
      val = (w == 16) ? 32'h12345678 : (w == 0) ? 32'h0 : $urandom;
      initVal[w] = val;
      sendBoth(1'b1, 4'hF, makeAddr(w), val);
    end
    drain();

    // Single read of word 0x10 through byte address 0x40.
    clearLogs();
    sendBoth(1'b0, 4'h0, 32'h40, 32'h0);
    acceptEdge = edgeCnt;
    repeat (6) idle();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("single_read_count%0d", k), 32'(seenLog[k].size()), 32'd1);
      if (seenLog[k].size() > 0) begin
        checkOutput($sformatf("single_read_latency%0d", k),
                    32'(seenLog[k][0].edgeNo - acceptEdge + 1), 32'(latOf(k)));
        checkOutput($sformatf("single_read_data%0d", k), seenLog[k][0].data, 32'h12345678);
      end
    end

    // Partial-strobe write over a zero word.
    clearLogs();
    sendBoth(1'b1, 4'b0101, 32'h0, 32'hAABBCCDD);
    sendBoth(1'b0, 4'h0, 32'h0, 32'h0);
    drain();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("byte_write_count%0d", k), 32'(seenLog[k].size()), 32'd2);
      if (seenLog[k].size() > 0)
        checkOutput($sformatf("byte_write_data%0d", k), seenLog[k][$].data, 32'h00BB00DD);
    end

    // Write then read of the same word on the very next cycle.
    clearLogs();
    sendBoth(1'b1, 4'hF, 32'h80, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
    drain();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("raw_count%0d", k), 32'(seenLog[k].size()), 32'd2);
      if (seenLog[k].size() == 2) begin
        checkOutput($sformatf("raw_write_rdata%0d", k), seenLog[k][0].data, 32'h0);
        checkOutput($sformatf("raw_read_rdata%0d", k), seenLog[k][1].data, 32'hCAFEF00D);
        checkOutput($sformatf("raw_spacing%0d", k), 32'(seenLog[k][1].edgeNo - seenLog[k][0].edgeNo), 32'd1);
      end
    end

    // Request held high into a full LAT=4 queue.
    clearLogs();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 32'(4 * (c + 1)), 32'h0);
      aPat[c] = lastAddrOk[1];
      dPat[c] = lastDataOk[1];
    end
    drain();
    checkOutput("full_addr_ok_pattern", 32'(aPat), 32'b100011);
    checkOutput("full_data_ok_pattern", 32'(dPat), 32'b110000);
    if (seenLog[1].size() >= 2) begin
      checkOutput("full_order_first", seenLog[1][0].data, initVal[1]);
      checkOutput("full_order_second", seenLog[1][1].data, initVal[2]);
    end else begin
      checkOutput("full_resp_count", 32'(seenLog[1].size()), 32'd2);
    end

    // Upper address bits alias onto the same word.
    clearLogs();
    val = $urandom;
    sendBoth(1'b1, 4'hF, 32'h00001004, val);
    sendBoth(1'b0, 4'h0, 32'h00000004, 32'h0);
    drain();
    for (int k = 0; k < 2; k++) begin
      if (seenLog[k].size() > 0)
        checkOutput($sformatf("alias_data%0d", k), seenLog[k][$].data, val);
      else
        checkOutput($sformatf("alias_count%0d", k), 32'(seenLog[k].size()), 32'd2);
    end

    // Random traffic over the initialised window.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    4'($urandom), makeAddr($urandom_range(0, 31)), $urandom);
    end
    drain();

    // Reset with two reads in flight.
    val = $urandom;
    sendBoth(1'b1, 4'hF, 32'h14, val);
    drain();
    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h18, 32'h0);
    checkOutput("inflight_before_reset", 32'(expQ[1].size()), 32'd2);
    doReset();
    idle();
    checkOutput("addr_ok_after_reset0", 32'(lastAddrOk[0]), 32'd1);
    checkOutput("addr_ok_after_reset1", 32'(lastAddrOk[1]), 32'd1);
    repeat (6) idle();
    checkOutput("no_resp_after_reset0", 32'(seenLog[0].size()), 32'd0);
    checkOutput("no_resp_after_reset1", 32'(seenLog[1].size()), 32'd0);
    sendBoth(1'b0, 4'h0, 32'h14, 32'h0);
    drain();
    for (int k = 0; k < 2; k++) begin
      if (seenLog[k].size() > 0)
        checkOutput($sformatf("mem_kept%0d", k), seenLog[k][$].data, val);
      else
        checkOutput($sformatf("mem_kept_count%0d", k), 32'(seenLog[k].size()), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
